clock_set_ctrl: RTL and testbench
=================================

# clock_set_ctrl

- Time-keeping controller for the digital clock.
- Owns the seconds/minutes/hours registers.
- Sequences normal counting from a 1 Hz tick.
- Runs a two-button set mode (select field, increment field) for adjusting hours and minutes.
- Sits between the tick generator / button debouncers and the display encoder.

## Interface
Parameters:
- SEC_MAX, 59, last seconds value before wrap
- MIN_MAX, 59, last minutes value before wrap
- HR_MAX, 23, last hours value before wrap

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset (rst=0 at a rising clk edge resets the block)
- tick  in  1  one-cycle pulse, once per second
- mode_btn  in  1  debounced level, field-select button
- inc_btn  in  1  debounced level, increment button
- seconds  out  8  current seconds, binary
- minutes  out  8  current minutes, binary
- hours  out  8  current hours, binary
- set_field  out  2  0=RUN, 1=SET_HR, 2=SET_MIN (drives display blink)
- day_pulse  out  1  one-cycle pulse on 23:59:59 -> 00:00:00 rollover in RUN

## Operation
- Button edges:
  - Each button is registered once (prev copy).
  - A press is the cycle where btn=1 and prev=0.
  - Prev registers reset to 1, so a button held through reset produces no press.
- FSM states: RUN, SET_HR, SET_MIN.
  - RUN -> SET_HR on mode press; seconds cleared to 0 on the same transition.
  - SET_HR -> SET_MIN on mode press.
  - SET_MIN -> RUN on mode press.
  - All other cycles: hold state.
- RUN behaviour:
  - On tick, seconds increments.
  - At seconds=SEC_MAX, seconds wraps to 0 and minutes increments.
  - At minutes=MIN_MAX with carry, minutes wraps and hours increments.
  - At hours=HR_MAX with carry, hours wraps to 0 and day_pulse=1 for that cycle.
  - inc press ignored.
- SET_HR: tick ignored and seconds held at 0. inc press gives hours+1, wrapping HR_MAX->0; no carry, no day_pulse.
- SET_MIN: tick ignored. inc press gives minutes+1, wrapping MIN_MAX->0; no carry into hours.
- Simultaneous mode and inc press in the same cycle: mode wins, inc discarded.
- Widths and limits:
  - All counts are 8-bit unsigned.
  - Values above MAX cannot be reached.
  - If one appears (e.g. forced in simulation), the next increment wraps it to 0.
- Reset values: seconds=0, minutes=0, hours=0, set_field=0 (RUN), day_pulse=0, state RUN.
- Reset mid-set: returns to RUN with time 00:00:00. Partial edits are not preserved.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- tick high at edge N: updated time and any carry are visible after edge N; day_pulse is high for the cycle following edge N only.
- Button press detected at edge N (btn=1, prev=0): state/field update visible after edge N. A held button generates exactly one press.
- Back-to-back ticks on consecutive cycles are each counted; no minimum spacing is required.
- A tick coinciding with a RUN->SET_HR mode press is discarded; seconds becomes 0.
- A tick coinciding with a SET_MIN->RUN mode press is discarded; counting resumes on the next tick.
- rst=0 overrides all other inputs at that edge.

## Structure
- Shared package clock_pkg:
  - state enum {RUN, SET_HR, SET_MIN} with fixed encodings 0/1/2, matching set_field.
  - Default limit constants 59/59/23.
- Sub-module wrap_counter, instantiated three times:
  - Inputs: clk, rst, clr, inc, max.
  - Outputs: 8-bit value, wrap (= inc & value==max).
- Controller top holds:
  - FSM and edge detectors.
  - Carry chaining gated by state: RUN uses the wrap chain; SET states drive inc directly from the button.

## Test plan
- Reset then 60 ticks -> seconds 0..59 then 0, minutes=1, hours=0, day_pulse never high.
- Preload via set mode to 23:59 and SET_MIN->RUN, then 60 ticks -> on the 60th tick time=00:00:00 and day_pulse=1 for exactly one cycle.
- From RUN at 10:20:35, mode press -> set_field=1 and seconds=0. 3 inc presses -> hours=13. mode press, then inc held 50 cycles -> minutes=21 (one increment). mode press -> set_field=0.
- In SET_HR with hours=23, one inc press -> hours=0, minutes unchanged, day_pulse=0. Ticks during SET states -> seconds stays 0.
- Same-cycle mode and inc press in SET_HR -> moves to SET_MIN, hours unchanged. mode_btn held high across reset release -> no transition.
- rst=0 asserted while in SET_MIN at 05:07 -> next cycle 00:00:00, set_field=0, and ticks count normally afterwards.

Source files
------------

// File: rtl/clock_pkg.sv
// clock_pkg: shared types and default limits for the digital clock.
//   state_e  : controller state, encodings match the set_field output
//   DEF_*    : default last-value-before-wrap for each time field
package clock_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } state_e;

  localparam int unsigned DEF_SEC_MAX = 59;
  localparam int unsigned DEF_MIN_MAX = 23 + 36; // 59
  localparam int unsigned DEF_HR_MAX  = 23;

endpackage

// File: rtl/wrap_counter.sv
// wrap_counter: 8-bit counter that wraps to 0 after reaching a limit.
//   clk   in   system clock
//   rst   in   synchronous active-low reset (value -> 0)
//   clr   in   synchronous clear, takes priority over inc
//   inc   in   increment enable
//   max   in   last value before wrap
//   value out  registered count
//   wrap  out  inc & value==max (carry into the next field)
module wrap_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  input  logic [7:0] max,
  output logic [7:0] value,
  output logic       wrap
);

  logic [7:0] value_q;

  // An out-of-range value (only reachable by forcing) wraps on the next inc.
  always_ff @(posedge clk) begin
    if (!rst)                   value_q <= 8'd0;
    else if (clr)               value_q <= 8'd0;
    else if (inc) begin
      if (value_q >= max)       value_q <= 8'd0;
      else                      value_q <= value_q + 8'd1;
    end
  end

  assign value = value_q;
  assign wrap  = inc & (value_q == max);

endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: time-keeping controller for the digital clock.
// Counts seconds/minutes/hours from a 1 Hz tick and runs a two-button
// set mode (mode selects field, inc bumps it).
//   clk       in   system clock
//   rst       in   synchronous active-low reset
//   tick      in   one-cycle pulse per second
//   mode_btn  in   debounced field-select button level
//   inc_btn   in   debounced increment button level
//   seconds   out  current seconds
//   minutes   out  current minutes
//   hours     out  current hours
//   set_field out  0=RUN 1=SET_HR 2=SET_MIN
//   day_pulse out  one-cycle pulse on 23:59:59 -> 00:00:00 in RUN
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned SEC_MAX = DEF_SEC_MAX,
  parameter int unsigned MIN_MAX = DEF_MIN_MAX,
  parameter int unsigned HR_MAX  = DEF_HR_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [7:0] seconds,
  output logic [7:0] minutes,
  output logic [7:0] hours,
  output logic [1:0] set_field,
  output logic       day_pulse
);

  state_e state_q;
  logic   mode_prev_q, inc_prev_q;
  logic   day_pulse_q;

  logic   mode_press, inc_press, inc_eff;
  logic   in_run, in_set_hr, in_set_min;
  logic   sec_clr, sec_inc, min_inc, hr_inc;
  logic   sec_wrap, min_wrap, hr_wrap;

  assign mode_press = mode_btn & ~mode_prev_q;
  assign inc_press  = inc_btn  & ~inc_prev_q;
  // Mode wins over a coincident inc press.
  assign inc_eff    = inc_press & ~mode_press;

  assign in_run     = (state_q == RUN);
  assign in_set_hr  = (state_q == SET_HR);
  assign in_set_min = (state_q == SET_MIN);

  // Entering set mode zeroes seconds and swallows any coincident tick.
  assign sec_clr = in_run & mode_press;
  assign sec_inc = in_run & tick & ~mode_press;
  // RUN follows the carry chain; set states bump the field directly.
  assign min_inc = in_run ? sec_wrap : (in_set_min & inc_eff);
  assign hr_inc  = in_run ? min_wrap : (in_set_hr  & inc_eff);

  wrap_counter u_sec (
    .clk(clk), .rst(rst), .clr(sec_clr), .inc(sec_inc),
    .max(8'(SEC_MAX)), .value(seconds), .wrap(sec_wrap)
  );

  wrap_counter u_min (
    .clk(clk), .rst(rst), .clr(1'b0), .inc(min_inc),
    .max(8'(MIN_MAX)), .value(minutes), .wrap(min_wrap)
  );

  wrap_counter u_hr (
    .clk(clk), .rst(rst), .clr(1'b0), .inc(hr_inc),
    .max(8'(HR_MAX)), .value(hours), .wrap(hr_wrap)
  );

  // Prev copies reset high so a button held through reset is not a press.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= RUN;
      mode_prev_q <= 1'b1;
      inc_prev_q  <= 1'b1;
      day_pulse_q <= 1'b0;
    end else begin
      mode_prev_q <= mode_btn;
      inc_prev_q  <= inc_btn;
      // hr_wrap only occurs in RUN via the chain; set-mode hour wrap has inc
      // from the button, so gate on RUN explicitly.
      day_pulse_q <= in_run & hr_wrap;
      if (mode_press) begin
        case (state_q)
          RUN:     state_q <= SET_HR;
          SET_HR:  state_q <= SET_MIN;
          default: state_q <= RUN;
        endcase
      end
    end
  end

  assign set_field = state_q;
  assign day_pulse = day_pulse_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       rst, tick, mode_btn, inc_btn;
  logic [7:0] seconds, minutes, hours;
  logic [1:0] set_field;
  logic       day_pulse;

  int ncmp  = 0;
  int nfail = 0;
  logic saw_day;

  clock_set_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .seconds(seconds), .minutes(minutes), .hours(hours),
    .set_field(set_field), .day_pulse(day_pulse)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s);
    check({tag, ".hr"},  hours,   8'(h));
    check({tag, ".min"}, minutes, 8'(m));
    check({tag, ".sec"}, seconds, 8'(s));
  endtask

  task automatic press_mode();
    mode_btn = 1'b1; step();
    mode_btn = 1'b0; step();
  endtask

  task automatic press_inc(input int n);
    for (int i = 0; i < n; i++) begin
      inc_btn = 1'b1; step();
      inc_btn = 1'b0; step();
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1; step();
      tick = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b0; tick = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0;
    step(); step();
    check_time("reset", 0, 0, 0);
    check("reset.field", 8'(set_field), 8'd0);
    check("reset.day",   8'(day_pulse), 8'd0);
    rst = 1'b1;
    step();

    // 60 back-to-back ticks: seconds 1..59 then 0, minute carry
    saw_day = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      tick = 1'b1; step(); tick = 1'b0;
      check("count.sec", seconds, 8'(i % 60));
      if (day_pulse) saw_day = 1'b1;
    end
    check("count.min", minutes, 8'd1);
    check("count.hr",  hours,   8'd0);
    check("count.noday", 8'(saw_day), 8'd0);

    // Preload 23:59 via set mode
    press_mode();
    check("sethr.field", 8'(set_field), 8'd1);
    press_inc(23);
    check("sethr.23", hours, 8'd23);
    inc_btn = 1'b1; step(); inc_btn = 1'b0;
    check("sethr.wrap", hours, 8'd0);
    check("sethr.wrap.min", minutes, 8'd1);
    check("sethr.wrap.day", 8'(day_pulse), 8'd0);
    step();
    press_inc(23);
    ticks(3);
    step();
    check("sethr.tick", seconds, 8'd0);
    press_mode();
    check("setmin.field", 8'(set_field), 8'd2);
    press_inc(58);
    ticks(2);
    step();
    check_time("preload", 23, 59, 0);
    // exit with a coincident tick: tick discarded
    tick = 1'b1; mode_btn = 1'b1; step();
    tick = 1'b0; mode_btn = 1'b0; step();
    check("exit.field", 8'(set_field), 8'd0);
    check("exit.sec",   seconds, 8'd0);
    ticks(59);
    check_time("pre_roll", 23, 59, 59);
    check("pre_roll.day", 8'(day_pulse), 8'd0);
    tick = 1'b1; step(); tick = 1'b0;
    check_time("roll", 0, 0, 0);
    check("roll.day", 8'(day_pulse), 8'd1);
    step();
    check("roll.day_off", 8'(day_pulse), 8'd0);

    // Build 10:20:35
    press_mode(); press_inc(10);
    press_mode(); press_inc(20);
    press_mode();
    ticks(35);
    check_time("t102035", 10, 20, 35);
    tick = 1'b1; mode_btn = 1'b1; step();
    tick = 1'b0; mode_btn = 1'b0;
    check("enter.field", 8'(set_field), 8'd1);
    check("enter.sec",   seconds, 8'd0);
    step();
    press_inc(3);
    check("inc3.hr", hours, 8'd13);
    press_mode();
    inc_btn = 1'b1;
    for (int i = 0; i < 50; i++) step();
    inc_btn = 1'b0; step();
    check("held.min", minutes, 8'd21);
    press_mode();
    check("back.field", 8'(set_field), 8'd0);
    check_time("back", 13, 21, 0);

    // Coincident mode+inc in SET_HR: mode wins
    press_mode();
    mode_btn = 1'b1; inc_btn = 1'b1; step();
    mode_btn = 1'b0; inc_btn = 1'b0; step();
    check("both.field", 8'(set_field), 8'd2);
    check("both.hr",    hours, 8'd13);
    check("both.min",   minutes, 8'd21);

    // Reach SET_MIN at 05:07
    press_mode(); press_mode();
    press_inc(16);
    press_mode();
    press_inc(46);
    check_time("t0507", 5, 7, 0);
    check("t0507.field", 8'(set_field), 8'd2);

    // Reset mid-set with mode held through reset release
    rst = 1'b0; mode_btn = 1'b1; step();
    check_time("rst_mid", 0, 0, 0);
    check("rst_mid.field", 8'(set_field), 8'd0);
    check("rst_mid.day",   8'(day_pulse), 8'd0);
    rst = 1'b1; step(); step();
    check("held_rst.field", 8'(set_field), 8'd0);
    mode_btn = 1'b0; step();
    ticks(3);
    check_time("after_rst", 0, 0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
